bc_game_ctrl: RTL and testbench
===============================

# bc_game_ctrl

Game sequencer for the two-player Bulls & Cows board. It accepts 4-digit BCD codes from the shared `guess` switches on each `confirm` press and validates them. It stores both players' secrets, alternates guess turns, and drives the `bc_score` unit. It publishes per-guess bulls/cows, the turn, the round count and the final winner to the display logic.

## Interface
- `MAX_ROUNDS`, default 8: guess rounds (one J1 plus one J2 guess each) before a draw is declared; range 1–15.
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `guess` in 16: four BCD digits; `[15:12]` is the leftmost digit.
- `confirm` in 1: player button, already synchronized and debounced to `clock`. Only its rising edge acts.
- `state_o` out 3: current FSM state, encoding from `bc_pkg::state_t`.
- `turn` out 1: player whose input is expected; 0 = J1, 1 = J2.
- `bulls` out 3: bulls of the last scored guess, 0–4.
- `cows` out 3: cows of the last scored guess, 0–4.
- `result_valid` out 1: one-cycle pulse when `bulls`/`cows` update.
- `err` out 1: one-cycle pulse when a confirmed code is invalid.
- `winner` out 2: 00 none, 01 J1, 10 J2, 11 draw.
- `round` out 4: completed rounds.

## Operation
- Confirm edge: `cfm_edge = confirm & ~confirm_q`, where `confirm_q` is a register. `guess` is sampled in the same cycle that `cfm_edge` is high. Edges occurring in `SCORE` or `FIM` are discarded and not queued.
- A code is valid when every nibble is ≤ 9 and all four nibbles are pairwise distinct.
  - An invalid code on `cfm_edge` in any input state pulses `err` for one cycle.
  - After an invalid code, nothing is latched and the state is unchanged.
- States are `SECRET_J1`, `SECRET_J2`, `GUESS_J1`, `GUESS_J2`, `SCORE`, `FIM`.
  - `SECRET_J1` + valid code: store `secret_j1`, go to `SECRET_J2`, `turn` = 1.
  - `SECRET_J2` + valid code: store `secret_j2`, go to `GUESS_J1`, `turn` = 0.
  - `GUESS_Jx` + valid code: latch the guess and its target (`secret_j2` for J1, `secret_j1` for J2), then go to `SCORE`.
  - `SCORE`, J1 turn: if bulls = 4, set `winner` = 01 and go to `FIM`; otherwise go to `GUESS_J2`, `turn` = 1.
  - `SCORE`, J2 turn: if bulls = 4, set `winner` = 10 and go to `FIM`. Otherwise increment `round`. If `round` + 1 = `MAX_ROUNDS`, set `winner` = 11 and go to `FIM`; else go to `GUESS_J1`, `turn` = 0.
  - `FIM`: absorbing; only `reset` leaves it.
- Scoring: bulls = count of positions i where `g[i] == s[i]`. Cows = count of pairs (i, j), i ≠ j, with `g[i] == s[j]`. Because both codes have distinct digits, bulls + cows ≤ 4.
- `bulls`/`cows` hold their value until the next `result_valid`.

## Timing
- Reset values: state `SECRET_J1`, `turn` 0, `bulls` 0, `cows` 0, `result_valid` 0, `err` 0, `winner` 00, `round` 0, both secrets 0, `confirm_q` 0.
- `confirm` rises before clock edge t: `err` is high or the state has advanced after edge t.
- For a guess:
  - Edge t enters `SCORE`.
  - Edge t+1 registers `bulls`/`cows`, asserts `result_valid` and applies the `SCORE` transition.
  - `result_valid` is high from t+1 to t+2.
  - Latency from the first cycle `confirm` is high to valid results: 2 clocks.
- A held `confirm` produces exactly one action. A new action requires `confirm` to go low for at least one cycle.
- Reset asserted mid-`SCORE`: immediate return to reset values; the pending result is dropped and no `result_valid` pulse is produced.

## Structure
- `bc_pkg` contains:
  - `state_t` as `logic [2:0]` enum.
  - `winner_t` codes.
  - `DIGITS` = 4 and `DIGIT_W` = 4.
  - A `code_valid()` function.
- Sub-module `bc_score`: registered scorer. Inputs are `guess`, `secret` and `start`; outputs are `bulls`, `cows` and `valid`, with 1-cycle latency. It is driven by the controller in `SCORE`.

## Test plan
- Secrets 0x1234 (J1) and 0x5678 (J2); J1 guesses 0x5876 → `result_valid` after 2 clocks, `bulls` = 2, `cows` = 2, then `GUESS_J2`, `turn` = 1.
- In `SECRET_J1`, codes 0x1123 and 0x12A4 → one `err` pulse each, state stays `SECRET_J1`; then 0x1234 → `SECRET_J2`.
- Secrets as above; J1 guesses 0x5678 → `bulls` = 4, `winner` = 01, `FIM`; further confirms have no effect.
- `MAX_ROUNDS` = 2; J1 and J2 both guess 0x9012 twice (J1's guess vs secret 0x5678: `bulls` 0, `cows` 0; J2's guess vs secret 0x1234: `bulls` 0, `cows` 2) → after the 4th result, `round` = 2, `winner` = 11, `FIM`.
- `confirm` held high for 10 cycles in `SECRET_J1` with 0x1234, then 0x5678 presented → only `secret_j1` is stored; the state is `SECRET_J2`, not `GUESS_J1`.
- `reset` pulsed one cycle after a J1 guess confirm (in `SCORE`) → no `result_valid`; all outputs at reset values, state `SECRET_J1`.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types, sizes and the code-validity rule for the Bulls & Cows game sequencer.
package bc_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;
   localparam int CODE_W  = DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      SECRET_J1 = 3'd0,
      SECRET_J2 = 3'd1,
      GUESS_J1  = 3'd2,
      GUESS_J2  = 3'd3,
      SCORE     = 3'd4,
      FIM       = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_J1   = 2'b01,
      WIN_J2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   // A code is playable when every digit is decimal and no digit repeats.
   function automatic logic code_valid(input logic [CODE_W-1:0] code);
      logic               ok;
      logic [DIGIT_W-1:0] a;
      logic [DIGIT_W-1:0] b;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         a = code[i*DIGIT_W +: DIGIT_W];
         if (a > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < DIGITS; j++) begin
            b = code[j*DIGIT_W +: DIGIT_W];
            if (a == b) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bc_game_ctrl_if.sv
// Board-side bundle of the game sequencer: switch/button inputs and display outputs.
// Handshake: a rising edge of confirm is the only "valid"; there is no ready, so edges
// arriving while a guess is being scored or after the game ended are dropped, not queued.
interface bc_game_ctrl_if;

   logic [bc_pkg::CODE_W-1:0] guess;
   logic                      confirm;
   logic [2:0]                state_o;
   logic                      turn;
   logic [2:0]                bulls;
   logic [2:0]                cows;
   logic                      result_valid;
   logic                      err;
   logic [1:0]                winner;
   logic [3:0]                round;

   modport master (
      output guess, confirm,
      input  state_o, turn, bulls, cows, result_valid, err, winner, round
   );

   modport slave (
      input  guess, confirm,
      output state_o, turn, bulls, cows, result_valid, err, winner, round
   );

endinterface

// File: rtl/bc_score.sv
// Registered bulls/cows scorer: one cycle after start, bulls/cows/valid reflect guess vs secret.
module bc_score
   import bc_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [CODE_W-1:0] guess_i,
   input  logic [CODE_W-1:0] secret_i,
   input  logic              start_i,
   output logic [2:0]        bulls_o,
   output logic [2:0]        cows_o,
   output logic              valid_o
);

   logic [2:0] bulls_d, cows_d;
   logic [2:0] bulls_q, cows_q;
   logic       valid_q;

   always_comb begin
      bulls_d = '0;
      cows_d  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = 0; j < DIGITS; j++) begin
            if (guess_i[i*DIGIT_W +: DIGIT_W] == secret_i[j*DIGIT_W +: DIGIT_W]) begin
               if (i == j) bulls_d = bulls_d + 3'd1;
               else        cows_d  = cows_d + 3'd1;
            end
         end
      end
   end

   // Results hold between scorings so the display keeps the last guess.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bulls_q <= '0;
         cows_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= start_i;
         if (start_i) begin
            bulls_q <= bulls_d;
            cows_q  <= cows_d;
         end
      end
   end

   assign bulls_o = bulls_q;
   assign cows_o  = cows_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/bc_game_ctrl.sv
// Two-player Bulls & Cows sequencer: collects secrets, alternates guesses, scores them
// through bc_score and declares a winner or a draw after MAX_ROUNDS rounds.
module bc_game_ctrl
   import bc_pkg::*;
#(
   parameter int MAX_ROUNDS = 8
) (
   input  logic           clock,
   input  logic           reset,
   bc_game_ctrl_if.slave  bus
);

   state_t            state_q, state_d;
   logic              confirm_q;
   logic              turn_q, turn_d;
   logic              err_q, err_d;
   winner_t           winner_q, winner_d;
   logic [3:0]        round_q, round_d;
   logic [CODE_W-1:0] secret_j1_q, secret_j1_d;
   logic [CODE_W-1:0] secret_j2_q, secret_j2_d;
   logic [CODE_W-1:0] guess_q, guess_d;
   logic [CODE_W-1:0] target_q, target_d;
   logic              score_start;

   logic              cfm_edge;
   logic              in_input;
   logic              accept;
   logic              reject;
   logic              full_match;
   logic              last_round;

   logic [2:0]        bulls_w, cows_w;
   logic              valid_w;

   assign cfm_edge = bus.confirm & ~confirm_q;
   assign in_input = (state_q == SECRET_J1) || (state_q == SECRET_J2) ||
                     (state_q == GUESS_J1)  || (state_q == GUESS_J2);
   assign accept   = cfm_edge & in_input &  code_valid(bus.guess);
   assign reject   = cfm_edge & in_input & ~code_valid(bus.guess);

   // Four bulls means the codes are identical, so the SCORE decision needs no
   // registered scorer output and can be taken on the same edge that publishes it.
   assign full_match = (guess_q == target_q);
   assign last_round = (round_q == 4'(MAX_ROUNDS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= SECRET_J1;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SECRET_J1: if (accept) state_d = SECRET_J2;
         SECRET_J2: if (accept) state_d = GUESS_J1;
         GUESS_J1,
         GUESS_J2:  if (accept) state_d = SCORE;
         SCORE: begin
            if (full_match)     state_d = FIM;
            else if (!turn_q)   state_d = GUESS_J2;
            else if (last_round) state_d = FIM;
            else                state_d = GUESS_J1;
         end
         FIM:       state_d = FIM;
         default:   state_d = SECRET_J1;
      endcase
   end

   always_comb begin
      err_d       = reject;
      turn_d      = turn_q;
      winner_d    = winner_q;
      round_d     = round_q;
      secret_j1_d = secret_j1_q;
      secret_j2_d = secret_j2_q;
      guess_d     = guess_q;
      target_d    = target_q;
      score_start = 1'b0;
      case (state_q)
         SECRET_J1: if (accept) begin
            secret_j1_d = bus.guess;
            turn_d      = 1'b1;
         end
         SECRET_J2: if (accept) begin
            secret_j2_d = bus.guess;
            turn_d      = 1'b0;
         end
         GUESS_J1: if (accept) begin
            guess_d  = bus.guess;
            target_d = secret_j2_q;
         end
         GUESS_J2: if (accept) begin
            guess_d  = bus.guess;
            target_d = secret_j1_q;
         end
         SCORE: begin
            score_start = 1'b1;
            if (!turn_q) begin
               if (full_match) winner_d = WIN_J1;
               else            turn_d   = 1'b1;
            end else if (full_match) begin
               winner_d = WIN_J2;
            end else begin
               round_d = round_q + 4'd1;
               if (last_round) winner_d = WIN_DRAW;
               else            turn_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         confirm_q   <= 1'b0;
         turn_q      <= 1'b0;
         err_q       <= 1'b0;
         winner_q    <= WIN_NONE;
         round_q     <= '0;
         secret_j1_q <= '0;
         secret_j2_q <= '0;
         guess_q     <= '0;
         target_q    <= '0;
      end else begin
         confirm_q   <= bus.confirm;
         turn_q      <= turn_d;
         err_q       <= err_d;
         winner_q    <= winner_d;
         round_q     <= round_d;
         secret_j1_q <= secret_j1_d;
         secret_j2_q <= secret_j2_d;
         guess_q     <= guess_d;
         target_q    <= target_d;
      end
   end

   bc_score u_score (
      .clock    (clock),
      .reset    (reset),
      .guess_i  (guess_q),
      .secret_i (target_q),
      .start_i  (score_start),
      .bulls_o  (bulls_w),
      .cows_o   (cows_w),
      .valid_o  (valid_w)
   );

   assign bus.state_o      = state_q;
   assign bus.turn         = turn_q;
   assign bus.bulls        = bulls_w;
   assign bus.cows         = cows_w;
   assign bus.result_valid = valid_w;
   assign bus.err          = err_q;
   assign bus.winner       = winner_q;
   assign bus.round        = round_q;

endmodule

// File: tb/tb_bc_game_ctrl.sv
// Directed and randomized bench for bc_game_ctrl against a game-level reference model.
module tb_bc_game_ctrl;
   import bc_pkg::*;

   localparam int MR = 2;

   logic clock;
   logic reset;
   bc_game_ctrl_if bus ();

   bc_game_ctrl #(.MAX_ROUNDS(MR)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_fail = 0;

   // model: phase 0 = J1 secret, 1 = J2 secret, 2 = guessing, 3 = scoring, 4 = over
   int          m_phase, m_player, m_round, m_winner, m_bulls, m_cows;
   logic [15:0] m_sec [2];
   logic [15:0] m_pend;
   logic        exp_err;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int digit_at(input logic [15:0] c, input int pos);
      return int'((c >> (4 * (3 - pos))) & 16'hF);
   endfunction

   function automatic bit m_valid(input logic [15:0] c);
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
         int d = digit_at(c, i);
         if (d > 9) return 0;
         if (seen[d]) return 0;
         seen[d] = 1'b1;
      end
      return 1;
   endfunction

   function automatic logic [15:0] rand_valid();
      int          used = 0;
      logic [15:0] c = '0;
      for (int i = 0; i < 4; i++) begin
         int d;
         do d = $urandom_range(0, 9); while (used[d]);
         used[d] = 1'b1;
         c = (c << 4) | 16'(d);
      end
      return c;
   endfunction

   function automatic logic [2:0] exp_state();
      case (m_phase)
         0:       return SECRET_J1;
         1:       return SECRET_J2;
         2:       return (m_player == 0) ? GUESS_J1 : GUESS_J2;
         3:       return SCORE;
         default: return FIM;
      endcase
   endfunction

   function automatic logic exp_turn();
      if (m_phase == 0) return 1'b0;
      if (m_phase == 1) return 1'b1;
      return m_player[0];
   endfunction

   task automatic model_reset();
      m_phase = 0; m_player = 0; m_round = 0; m_winner = 0;
      m_bulls = 0; m_cows = 0; m_sec[0] = '0; m_sec[1] = '0; m_pend = '0;
      exp_err = 1'b0;
   endtask

   task automatic model_confirm(input logic [15:0] c, output bit scoring);
      scoring = 0;
      exp_err = 1'b0;
      if (m_phase <= 2) begin
         if (!m_valid(c)) exp_err = 1'b1;
         else if (m_phase == 0) begin m_sec[0] = c; m_phase = 1; end
         else if (m_phase == 1) begin m_sec[1] = c; m_phase = 2; m_player = 0; end
         else begin m_pend = c; m_phase = 3; scoring = 1; end
      end
   endtask

   task automatic model_score();
      logic [15:0] tgt = m_sec[1 - m_player];
      int smask = 0;
      int common = 0;
      m_bulls = 0;
      for (int i = 0; i < 4; i++) begin
         smask[digit_at(tgt, i)] = 1'b1;
         if (digit_at(m_pend, i) == digit_at(tgt, i)) m_bulls++;
      end
      for (int i = 0; i < 4; i++) if (smask[digit_at(m_pend, i)]) common++;
      m_cows = common - m_bulls;
      if (m_bulls == 4) begin
         m_winner = m_player + 1; m_phase = 4;
      end else if (m_player == 0) begin
         m_player = 1; m_phase = 2;
      end else begin
         m_round++;
         if (m_round == MR) begin m_winner = 3; m_phase = 4; end
         else begin m_player = 0; m_phase = 2; end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".state"},  16'(bus.state_o), 16'(exp_state()));
      check_eq({tag, ".turn"},   16'(bus.turn),    16'(exp_turn()));
      check_eq({tag, ".bulls"},  16'(bus.bulls),   16'(m_bulls));
      check_eq({tag, ".cows"},   16'(bus.cows),    16'(m_cows));
      check_eq({tag, ".winner"}, 16'(bus.winner),  16'(m_winner));
      check_eq({tag, ".round"},  16'(bus.round),   16'(m_round));
   endtask

   task automatic do_reset();
      bus.confirm = 1'b0;
      bus.guess   = '0;
      reset       = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check_all("reset");
      check_eq("reset.rv",  16'(bus.result_valid), 16'd0);
      check_eq("reset.err", 16'(bus.err),          16'd0);
   endtask

   // Press confirm with code, keep it held for hold cycles while alt sits on the switches.
   task automatic press(input logic [15:0] code, input logic [15:0] alt, input int hold);
      bit scoring;
      @(negedge clock);
      bus.guess   = code;
      bus.confirm = 1'b1;
      @(posedge clock); #1;
      model_confirm(code, scoring);
      check_eq("edge.err", 16'(bus.err), 16'(exp_err));
      check_eq("edge.rv",  16'(bus.result_valid), 16'd0);
      check_all("edge");
      @(negedge clock);
      bus.guess = alt;
      @(posedge clock); #1;
      check_eq("next.err", 16'(bus.err), 16'd0);
      check_eq("next.rv",  16'(bus.result_valid), 16'(scoring));
      if (scoring) model_score();
      check_all("next");
      for (int k = 2; k < hold; k++) begin
         @(posedge clock); #1;
         check_eq("held.err", 16'(bus.err), 16'd0);
         check_eq("held.rv",  16'(bus.result_valid), 16'd0);
         check_eq("held.state", 16'(bus.state_o), 16'(exp_state()));
      end
      @(negedge clock);
      bus.confirm = 1'b0;
      @(posedge clock); #1;
      check_eq("low.rv",  16'(bus.result_valid), 16'd0);
      check_eq("low.err", 16'(bus.err), 16'd0);
   endtask

   initial begin
      model_reset();
      do_reset();

      // invalid codes in SECRET_J1, then setup and a 2-bull 2-cow guess
      press(16'h1123, 16'h0000, 2);
      press(16'h12A4, 16'h0000, 2);
      press(16'h1234, 16'h0000, 2);
      press(16'h5678, 16'h0000, 2);
      press(16'h5876, 16'h0000, 2);
      check_eq("dir.b2c2.state", 16'(bus.state_o), 16'(GUESS_J2));

      // immediate J1 win, then FIM ignores further presses
      do_reset();
      press(16'h1234, 16'h0000, 2);
      press(16'h5678, 16'h0000, 2);
      press(16'h5678, 16'h0000, 2);
      check_eq("dir.win.winner", 16'(bus.winner), 16'(WIN_J1));
      press(16'h1123, 16'h0000, 2);
      press(16'h9012, 16'h0000, 3);
      check_eq("dir.fim.state", 16'(bus.state_o), 16'(FIM));

      // draw after MR rounds
      do_reset();
      press(16'h1234, 16'h0000, 2);
      press(16'h5678, 16'h0000, 2);
      for (int k = 0; k < 4; k++) press(16'h9012, 16'h0000, 2);
      check_eq("dir.draw.winner", 16'(bus.winner), 16'(WIN_DRAW));
      check_eq("dir.draw.round",  16'(bus.round),  16'd2);

      // long hold stores only the first code
      do_reset();
      press(16'h1234, 16'h5678, 10);
      check_eq("dir.hold.state", 16'(bus.state_o), 16'(SECRET_J2));

      // reset while a guess is being scored
      do_reset();
      press(16'h1234, 16'h0000, 2);
      press(16'h5678, 16'h0000, 2);
      @(negedge clock);
      bus.guess   = 16'h5678;
      bus.confirm = 1'b1;
      @(posedge clock); #1;
      check_eq("rst.score.state", 16'(bus.state_o), 16'(SCORE));
      #2 reset = 1'b1;
      #1 check_eq("rst.async.state", 16'(bus.state_o), 16'(SECRET_J1));
      @(posedge clock); #1;
      check_eq("rst.rv", 16'(bus.result_valid), 16'd0);
      @(negedge clock);
      reset = 1'b0;
      bus.confirm = 1'b0;
      model_reset();
      check_all("rst.after");
      @(posedge clock); #1;
      check_eq("rst.rv2", 16'(bus.result_valid), 16'd0);

      // random games
      for (int g = 0; g < 8; g++) begin
         do_reset();
         for (int p = 0; p < 30 && m_phase != 4; p++) begin
            logic [15:0] c;
            int r = $urandom_range(0, 9);
            if (m_phase == 2 && r < 2)  c = m_sec[1 - m_player];
            else if (r < 5)              c = 16'($urandom());
            else                         c = rand_valid();
            press(c, rand_valid(), $urandom_range(2, 4));
         end
         press(rand_valid(), rand_valid(), 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
